// File: rtl/hazard_ctrl.sv
// Hazard sequencer for the 5-stage RV64 pipeline: load-use stall, redirect flush,
// ID->EX forward selects and multi-cycle mul/div occupancy of EX.
module hazard_ctrl #(
  parameter int MD_LAT = 8,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_is_load,
  input  logic              id_is_md,
  input  logic              ex_redirect,
  output logic              stall,
  output logic              flush_if,
  output logic              flush_id,
  output logic              md_busy,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  typedef enum logic {RUN, MD_BUSY} state_t;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic              ld;
  } slot_t;

  localparam logic [7:0] MD_LOAD = 8'(MD_LAT - 1);

  state_t     state;
  logic [7:0] cnt;
  slot_t      ex_s;
  slot_t      mem_s;

  logic       ex_wr, mem_wr;
  logic       hit_ex_a, hit_ex_b, hit_mem_a, hit_mem_b;
  logic       lu_haz, in_md, issue;
  logic [1:0] fwd_a_nxt, fwd_b_nxt;

  // A slot targeting x0 never produces a value anyone can depend on.
  function automatic logic is_writer(input slot_t s);
    return s.v && s.wr && (s.rd != '0);
  endfunction

  assign ex_wr     = is_writer(ex_s);
  assign mem_wr    = is_writer(mem_s);
  assign hit_ex_a  = id_use_rs1 & ex_wr  & (id_rs1 == ex_s.rd);
  assign hit_ex_b  = id_use_rs2 & ex_wr  & (id_rs2 == ex_s.rd);
  assign hit_mem_a = id_use_rs1 & mem_wr & (id_rs1 == mem_s.rd);
  assign hit_mem_b = id_use_rs2 & mem_wr & (id_rs2 == mem_s.rd);
  assign lu_haz    = ex_s.ld & (hit_ex_a | hit_ex_b);
  assign in_md     = (state == MD_BUSY);

  // Redirect is ignored while a mul/div owns EX; rst masks the combinational
  // outputs so every output reads 0 for as long as reset is held.
  assign stall    = ~rst & id_valid & (in_md | (lu_haz & ~ex_redirect));
  assign flush_if = ~rst & ex_redirect & ~in_md;
  assign flush_id = flush_if;
  assign issue    = id_valid & ~stall & ~flush_id;

  always_comb begin
    // NOTE: defaults first, so no branch leaves a select unassigned and infers a latch.
    fwd_a_nxt = 2'd0;
    fwd_b_nxt = 2'd0;
    if (hit_ex_a && !ex_s.ld) fwd_a_nxt = 2'd1;
    else if (hit_mem_a)       fwd_a_nxt = 2'd2;
    if (hit_ex_b && !ex_s.ld) fwd_b_nxt = 2'd1;
    else if (hit_mem_b)       fwd_b_nxt = 2'd2;
  end

  // The WB slot is never consulted (the register file bypasses its own write),
  // so the MEM slot simply retires instead of shifting into a dead register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the shadow slots are control state, not data storage, so they are reset.
      state   <= RUN;
      cnt     <= '0;
      ex_s    <= '0;
      mem_s   <= '0;
      fwd_a   <= 2'd0;
      fwd_b   <= 2'd0;
      md_busy <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every slot shifts from its pre-edge value.
      case (state)
        RUN: begin
          mem_s <= ex_s;
          ex_s  <= issue ? {1'b1, id_rd, id_regwrite, id_is_load} : '0;
          fwd_a <= issue ? fwd_a_nxt : 2'd0;
          fwd_b <= issue ? fwd_b_nxt : 2'd0;
          if (issue && id_is_md) begin
            state   <= MD_BUSY;
            cnt     <= MD_LOAD;
            md_busy <= 1'b1;
          end
        end
        MD_BUSY: begin
          mem_s <= '0;
          cnt   <= cnt - 8'd1;
          if (cnt == 8'd1) begin
            state   <= RUN;
            md_busy <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
